// File: rtl/rgb2gray_stream.sv
// Purpose : streaming RGB-to-gray converter, one component per transfer (R,G,B order), one gray per pixel.
// Latency : gray_o/valid_o valid the cycle after the B transfer; one pixel per three cycles sustained.
// Backpr. : only the completing B transfer stalls while a result is held unaccepted; R and G flow freely.
//
// Ports   : clk_i/rst_i (async active-high), clear_i (sync restart of the pixel phase),
//           mode_i (0 = average, 1 = luma, sampled on R), comp_i/valid_i/ready_o (input stream),
//           gray_o/valid_o/ready_i (output stream), count_o (delivered samples, wrapping).
// Config  : RGB2GRAY_LUMA_EN defined builds the luma coefficient path; undefined builds average only.
module rgb2gray_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] comp_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] gray_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int AW = DATA_W + 9;   // accumulator width
    localparam int PW = AW + 8;       // room for the x171 average scaling
    localparam logic [DATA_W-1:0] GRAY_MAX = '1;

    typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

    phase_t             phase_q, phase_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [DATA_W-1:0]  gray_q, gray_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               xfer;
    logic               deliver;
    logic [AW-1:0]      term;
    logic [AW-1:0]      sum;
    logic [PW-1:0]      avg_full;
    logic [DATA_W-1:0]  result;

    // Depends on registered state and ready_i only, never on valid_i.
    assign ready_o = !(phase_q == PH_B && valid_q && !ready_i);
    assign xfer    = valid_i && ready_o;
    assign deliver = valid_q && ready_i;

`ifdef RGB2GRAY_LUMA_EN
    logic          mode_q, mode_d;
    logic          pix_mode;
    logic [AW-1:0] coef;

    // On the R transfer the live mode_i applies; afterwards the sampled copy does.
    always_comb begin
        pix_mode = (phase_q == PH_R) ? mode_i : mode_q;
        case (phase_q)
            PH_R:    coef = AW'(77);
            PH_G:    coef = AW'(150);
            default: coef = AW'(29);
        endcase
        term = pix_mode ? AW'(comp_i) * coef : AW'(comp_i);
    end
`else
    logic unused_mode;
    assign unused_mode = mode_i;
    assign term        = AW'(comp_i);
`endif

    assign sum      = (phase_q == PH_R) ? term : acc_q + term;
    // (S * 171) >> 9 approximates S / 3.
    assign avg_full = (PW'(sum) * PW'(171)) >> 9;

    always_comb begin
        result = (avg_full > PW'(GRAY_MAX)) ? GRAY_MAX : avg_full[DATA_W-1:0];
`ifdef RGB2GRAY_LUMA_EN
        // Coefficients sum to 256, so S >> 8 always fits DATA_W bits.
        if (pix_mode) result = sum[DATA_W+7:8];
`endif
    end

    always_comb begin
        phase_d = phase_q;
        acc_d   = acc_q;
        gray_d  = gray_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
`ifdef RGB2GRAY_LUMA_EN
        mode_d  = mode_q;
`endif
        if (deliver) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        // Restart wins over a same-cycle transfer: the component is dropped.
        if (clear_i) begin
            phase_d = PH_R;
            acc_d   = '0;
        end else if (xfer) begin
            acc_d = sum;
            case (phase_q)
                PH_R: begin
                    phase_d = PH_G;
`ifdef RGB2GRAY_LUMA_EN
                    mode_d  = mode_i;
`endif
                end
                PH_G: phase_d = PH_B;
                PH_B: begin
                    phase_d = PH_R;
                    gray_d  = result;
                    valid_d = 1'b1;   // a load beats a same-cycle delivery
                end
                default: phase_d = PH_R;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= PH_R;
            acc_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
`ifdef RGB2GRAY_LUMA_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            acc_q   <= acc_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
`ifdef RGB2GRAY_LUMA_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign gray_o  = gray_q;
    assign valid_o = valid_q;
    assign count_o = cnt_q;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Purpose : self-checking bench for rgb2gray_stream against a per-pixel arithmetic reference.
// Latency : expects a result one cycle after each B transfer.
// Backpr. : drives ready_i low in directed and random windows; expects the held result to persist.
module tb_rgb2gray_stream;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int GMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] comp = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] gray_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [CW-1:0] count_o;

    rgb2gray_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear),
        .mode_i  (mode),
        .comp_i  (comp),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .gray_o  (gray_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: components collected for the current pixel, results awaiting delivery.
    int exp_q[$];
    int comps[3];
    int ncomp   = 0;
    bit pix_mode = 1'b0;
    int exp_cnt = 0;

    function automatic int ref_gray(int r, int g, int b, bit m);
        int s;
`ifdef RGB2GRAY_LUMA_EN
        if (m) return (r * 77 + g * 150 + b * 29) / 256;
`endif
        s = ((r + g + b) * 171) / 512;
        return (s > GMAX) ? GMAX : s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ncomp   = 0;
        exp_cnt = 0;
    endtask

    // One clock cycle: drive, check at negedge, advance the reference, check after the edge.
    task automatic step(input bit v, input int c, input bit m, input bit r, input bit cl);
        bit pend, exp_rdy, dlv, xfer, newres;
        valid_i = v;
        comp    = DW'(c);
        mode    = m;
        ready_i = r;
        clear   = cl;
        @(negedge clk);
        pend    = (exp_q.size() != 0);
        exp_rdy = !(ncomp == 2 && pend && !r);
        check("ready_o", ready_o, exp_rdy);
        check("valid_o", valid_o, pend);
        if (pend) check("gray_o", gray_o, exp_q[0]);
        dlv    = pend && r;
        xfer   = v && exp_rdy;
        newres = 1'b0;
        if (dlv) begin
            void'(exp_q.pop_front());
            exp_cnt = (exp_cnt + 1) % (1 << CW);
        end
        if (cl) begin
            ncomp = 0;
        end else if (xfer) begin
            if (ncomp == 0) pix_mode = m;
            comps[ncomp] = c;
            ncomp++;
            if (ncomp == 3) begin
                exp_q.push_back(ref_gray(comps[0], comps[1], comps[2], pix_mode));
                ncomp  = 0;
                newres = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("count_o", count_o, exp_cnt);
        if (newres) begin
            check("latency valid_o", valid_o, 1);
            check("latency gray_o", gray_o, exp_q[exp_q.size()-1]);
        end
    endtask

    task automatic pixel(input int r, input int g, input int b, input bit m);
        step(1'b1, r, m, 1'b1, 1'b0);
        step(1'b1, g, m, 1'b1, 1'b0);
        step(1'b1, b, m, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst gray_o", gray_o, 0);
        check("rst valid_o", valid_o, 0);
        check("rst count_o", count_o, 0);
        check("rst ready_o", ready_o, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Power-on reset
        apply_reset();

        // Average and luma directed pixels (luma collapses to average when not built)
        pixel(10, 20, 30, 1'b0);
        pixel(255, 255, 255, 1'b0);
        pixel(0, 0, 3, 1'b0);
        pixel(255, 255, 255, 1'b1);
        pixel(100, 50, 25, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
`ifndef RGB2GRAY_LUMA_EN
        check("avg-only 100,50,25", ref_gray(100, 50, 25, 1'b1), 58);
`endif

        // Back-pressure: pixel 1 completes, then ready_i held low
        apply_reset();
        pixel(30, 60, 90, 1'b0);
        step(1'b1, 11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 22, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 33, 1'b0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("bp count_o", count_o, 2);

        // Restart during PH_G drops that component
        step(1'b1, 50, 1'b0, 1'b1, 1'b0);
        step(1'b1, 60, 1'b0, 1'b1, 1'b1);
        pixel(90, 90, 90, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Reset mid-pixel with a pending output
        step(1'b1, 1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0);
        apply_reset();
        pixel(40, 80, 120, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Random traffic, long enough to wrap count_o
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) != 0, int'($urandom_range(0, GMAX)),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
